hemaia_clock_divider_ctrl: RTL and testbench

Sequencer that reprograms a bank of NumChannels clock dividers from a single request/response configuration port.
For each divisor change it runs a glitch-safe sequence: gate the channel's clock enable, pulse the new divisor into the divider, wait for the divider to adopt it, then ungate.
It sits between the clock/reset CSR block and the per-domain dividers and gates in the HeMAiA clk/rst controller.
It keeps a shadow copy of each channel's current divisor.

---
 rtl/hemaia_clock_divider_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_hemaia_clock_divider_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hemaia_clock_divider_ctrl.sv
// ---------------------------------------------------------------------------
// hemaia_clock_divider_ctrl
//
// Purpose:
//   Sequencer that reprograms a bank of NumChannels clock dividers from a
//   single request/response configuration port. A divisor change runs a
//   glitch-safe sequence on the target channel: gate its clock enable, pulse
//   the new divisor into the divider, wait for the divider to adopt it, then
//   ungate. A shadow copy of every channel's current divisor is kept so that
//   requests that would not change anything are answered without touching the
//   clock.
//
// Ports:
//   clk_i          controller clock (undivided source clock)
//   rst_ni         asynchronous active-low reset (shared with the dividers)
//   req_valid_i    configuration request valid
//   req_ready_o    high in IDLE; request taken on valid & ready
//   req_chan_i     target channel index
//   req_divisor_i  requested divisor
//   resp_valid_o   response valid (RESP state)
//   resp_ready_i   response consumed on valid & ready
//   resp_error_o   1 = request rejected, nothing programmed
//   div_divisor_o  per-channel divisor to the dividers (channel c at [c*W +: W])
//   div_valid_o    per-channel one-cycle program pulse
//   clk_en_o       per-channel clock-gate enable (1 = running)
//   cur_divisor_o  shadow of the currently programmed divisors
//   busy_o         high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module hemaia_clock_divider_ctrl #(
  parameter int unsigned NumChannels      = 4,
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned GateCycles       = 4,
  parameter int unsigned SettleCycles     = 32,
  localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [ChanW-1:0]                         req_chan_i,
  input  logic [MaxDivisionWidth-1:0]              req_divisor_i,
  output logic                                     resp_valid_o,
  input  logic                                     resp_ready_i,
  output logic                                     resp_error_o,
  output logic [NumChannels*MaxDivisionWidth-1:0]  div_divisor_o,
  output logic [NumChannels-1:0]                   div_valid_o,
  output logic [NumChannels-1:0]                   clk_en_o,
  output logic [NumChannels*MaxDivisionWidth-1:0]  cur_divisor_o,
  output logic                                     busy_o
);

  // One shared down-counter times both the gate and the settle phase.
  localparam int unsigned MaxCnt = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [MaxDivisionWidth-1:0] DefDiv     = MaxDivisionWidth'(DefaultDivision);
  localparam logic [CntW-1:0]             GateLoad   = CntW'(GateCycles - 1);
  localparam logic [CntW-1:0]             SettleLoad = CntW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE   = 3'd1,
    PROG   = 3'd2,
    SETTLE = 3'd3,
    UNGATE = 3'd4,
    RESP   = 3'd5
  } state_e;

  state_e                                       state_q, state_d;
  logic [ChanW-1:0]                             chan_q, chan_d;
  logic [MaxDivisionWidth-1:0]                  div_q, div_d;
  logic                                         err_q, err_d;
  logic [CntW-1:0]                              cnt_q, cnt_d;
  logic [NumChannels-1:0][MaxDivisionWidth-1:0] cur_q, cur_d;

  // Request classification, evaluated against the live request inputs while
  // IDLE. The channel range check comes first so that an out-of-range index
  // never selects a shadow entry.
  logic chan_ok;
  logic div_zero;
  logic same_div;

  always_comb begin
    chan_ok  = (32'(req_chan_i) < NumChannels);
    div_zero = (req_divisor_i == '0);
    same_div = 1'b0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if ((32'(req_chan_i) == c) && (cur_q[c] == req_divisor_i)) begin
        same_div = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    div_d   = div_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          chan_d = req_chan_i;
          div_d  = req_divisor_i;
          if (!chan_ok || div_zero) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (same_div) begin
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = GateLoad;
            state_d = GATE;
          end
        end
      end

      GATE: begin
        if (cnt_q == '0) begin
          state_d = PROG;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      // The shadow follows the divider: it takes the new value as the
      // program pulse is delivered.
      PROG: begin
        for (int unsigned c = 0; c < NumChannels; c++) begin
          if (32'(chan_q) == c) begin
            cur_d[c] = div_q;
          end
        end
        cnt_d   = SettleLoad;
        state_d = SETTLE;
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = UNGATE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      UNGATE: begin
        state_d = RESP;
      end

      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      chan_q  <= '0;
      div_q   <= DefDiv;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      cur_q   <= {NumChannels{DefDiv}};
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      div_q   <= div_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // Outputs decode purely from registered state. During PROG the divider
  // port already carries the new divisor; afterwards it is held through the
  // shadow, which has taken the same value.
  always_comb begin
    clk_en_o      = '1;
    div_valid_o   = '0;
    div_divisor_o = cur_q;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (32'(chan_q) == c) begin
        if ((state_q == GATE) || (state_q == PROG) || (state_q == SETTLE)) begin
          clk_en_o[c] = 1'b0;
        end
        if (state_q == PROG) begin
          div_valid_o[c]                                     = 1'b1;
          div_divisor_o[c*MaxDivisionWidth +: MaxDivisionWidth] = div_q;
        end
      end
    end
  end

  assign cur_divisor_o = cur_q;
  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign resp_valid_o  = (state_q == RESP);
  assign resp_error_o  = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_hemaia_clock_divider_ctrl.sv
`timescale 1ns/1ps

module tb_hemaia_clock_divider_ctrl;

  localparam int NC  = 4;
  localparam int W   = 4;
  localparam int DEF = 1;
  localparam int G   = 4;
  localparam int S   = 32;
  localparam int DRAIN_LIMIT = 20000;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_chan_i;
  logic [W-1:0]      req_divisor_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic              resp_error_o;
  logic [NC*W-1:0]   div_divisor_o;
  logic [NC-1:0]     div_valid_o;
  logic [NC-1:0]     clk_en_o;
  logic [NC*W-1:0]   cur_divisor_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  hemaia_clock_divider_ctrl #(
    .NumChannels(NC), .MaxDivisionWidth(W), .DefaultDivision(DEF),
    .GateCycles(G), .SettleCycles(S)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_chan_i(req_chan_i), .req_divisor_i(req_divisor_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_error_o(resp_error_o),
    .div_divisor_o(div_divisor_o), .div_valid_o(div_valid_o), .clk_en_o(clk_en_o),
    .cur_divisor_o(cur_divisor_o), .busy_o(busy_o)
  );

  // Three-channel instance: a 2-bit channel index can name a missing channel.
  logic          v3, rdy3, rv3, rr3, err3, busy3;
  logic [1:0]    c3;
  logic [W-1:0]  d3;
  logic [3*W-1:0] divo3, cur3;
  logic [2:0]    dv3, clk3;

  hemaia_clock_divider_ctrl #(
    .NumChannels(3), .MaxDivisionWidth(W), .DefaultDivision(DEF),
    .GateCycles(G), .SettleCycles(S)
  ) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(v3), .req_ready_o(rdy3),
    .req_chan_i(c3), .req_divisor_i(d3),
    .resp_valid_o(rv3), .resp_ready_i(rr3), .resp_error_o(err3),
    .div_divisor_o(divo3), .div_valid_o(dv3), .clk_en_o(clk3),
    .cur_divisor_o(cur3), .busy_o(busy3)
  );

  typedef enum int {K_ERR, K_SKIP, K_PROG} kind_e;
  typedef struct { int t; int chan; int dv; kind_e kind; } op_t;
  typedef struct { int chan; int dv; } stim_t;

  op_t    exp_q[$];
  stim_t  stim_q[$];
  logic [W-1:0] mcur [NC];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  bit     rr_random = 1'b0;
  bit     rr_force_low = 1'b0;
  bit     mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NC*W-1:0] pack_model();
    logic [NC*W-1:0] v;
    for (int c = 0; c < NC; c++) v[c*W +: W] = mcur[c];
    return v;
  endfunction

  // Request driver: holds valid until accepted, classifies each accepted
  // request from the divisor rules and pushes the expected outcome.
  initial begin : driver
    bit  hs;
    int  hs_t;
    op_t op;
    req_valid_i   = 1'b0;
    req_chan_i    = '0;
    req_divisor_i = '0;
    forever begin
      @(negedge clk_i);
      hs   = req_valid_i && req_ready_o && rst_ni;
      hs_t = cyc;
      @(posedge clk_i); #1;
      if (hs && rst_ni) begin
        op.t    = hs_t;
        op.chan = int'(req_chan_i);
        op.dv   = int'(req_divisor_i);
        if (op.dv == 0 || op.chan >= NC) op.kind = K_ERR;
        else if (int'(mcur[op.chan]) == op.dv) op.kind = K_SKIP;
        else op.kind = K_PROG;
        exp_q.push_back(op);
        void'(stim_q.pop_front());
        req_valid_i = 1'b0;
      end
      if (!req_valid_i && stim_q.size() > 0 && rst_ni) begin
        req_valid_i   = 1'b1;
        req_chan_i    = 2'(stim_q[0].chan);
        req_divisor_i = W'(stim_q[0].dv);
      end
    end
  end

  initial begin : rr_driver
    resp_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (rr_force_low) resp_ready_i = 1'b0;
      else if (rr_random) resp_ready_i = ($urandom_range(0, 3) != 0);
      else resp_ready_i = 1'b1;
    end
  end

  // Monitor: derives every output from the head of the expectation queue
  // and the cycle offset since its handshake.
  initial begin : monitor
    op_t op;
    int k;
    logic [NC-1:0]   e_clk, e_dv;
    logic [NC*W-1:0] e_cur, e_divo, e_def;
    logic e_resp, e_busy, e_err;
    for (int c = 0; c < NC; c++) e_def[c*W +: W] = W'(DEF);
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete();
        for (int c = 0; c < NC; c++) mcur[c] = W'(DEF);
        chk("rst req_ready", req_ready_o, 1);
        chk("rst busy", busy_o, 0);
        chk("rst resp_valid", resp_valid_o, 0);
        chk("rst resp_error", resp_error_o, 0);
        chk("rst clk_en", clk_en_o, {NC{1'b1}});
        chk("rst div_valid", div_valid_o, 0);
        chk("rst cur_divisor", cur_divisor_o, e_def);
        chk("rst div_divisor", div_divisor_o, e_def);
      end else if (mon_en) begin
        e_clk  = '1;
        e_dv   = '0;
        e_resp = 1'b0;
        e_busy = 1'b0;
        e_err  = 1'b0;
        e_cur  = pack_model();
        e_divo = e_cur;
        if (exp_q.size() > 0) begin
          op     = exp_q[0];
          k      = cyc - op.t;
          e_busy = 1'b1;
          e_err  = (op.kind == K_ERR);
          if (op.kind == K_PROG) begin
            if (k >= 1 && k <= G + S + 1) e_clk[op.chan] = 1'b0;
            if (k == G + 1) e_dv[op.chan] = 1'b1;
            if (k >= G + 1) e_divo[op.chan*W +: W] = W'(op.dv);
            if (k >= G + 2) e_cur[op.chan*W +: W] = W'(op.dv);
            e_resp = (k >= G + S + 3);
          end else begin
            e_resp = (k >= 1);
          end
        end
        chk("req_ready", req_ready_o, !e_busy);
        chk("busy", busy_o, e_busy);
        chk("resp_valid", resp_valid_o, e_resp);
        chk("clk_en", clk_en_o, e_clk);
        chk("div_valid", div_valid_o, e_dv);
        chk("cur_divisor", cur_divisor_o, e_cur);
        chk("div_divisor", div_divisor_o, e_divo);
        if (e_resp && resp_valid_o) chk("resp_error", resp_error_o, e_err);
        if (e_resp && resp_valid_o && resp_ready_i) begin
          if (op.kind == K_PROG) mcur[op.chan] = W'(op.dv);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((stim_q.size() > 0 || req_valid_i || exp_q.size() > 0) && n < DRAIN_LIMIT) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain within bound", (n < DRAIN_LIMIT), 1);
    @(negedge clk_i);
  endtask

  task automatic push_req(input int chan, input int dv);
    stim_t s;
    s.chan = chan;
    s.dv   = dv;
    stim_q.push_back(s);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, hold, t0, ch, r;
    rst_ni = 1'b0;
    v3 = 1'b0; c3 = '0; d3 = '0; rr3 = 1'b0;
    for (int c = 0; c < NC; c++) mcur[c] = W'(DEF);
    repeat (3) @(negedge clk_i);
    chk("reset req_ready const", req_ready_o, 1);
    chk("reset clk_en const", clk_en_o, 4'b1111);
    chk("reset cur const", cur_divisor_o, 16'h1111);
    chk("reset resp_valid const", resp_valid_o, 0);
    chk("reset div_valid const", div_valid_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Missing channel on the 3-channel instance.
    @(posedge clk_i); #1;
    v3 = 1'b1; c3 = 2'd3; d3 = 4'd2; rr3 = 1'b1;
    @(negedge clk_i);
    chk("ch3 ready", rdy3, 1);
    @(posedge clk_i); #1;
    v3 = 1'b0;
    @(negedge clk_i);
    chk("ch3 resp_valid", rv3, 1);
    chk("ch3 resp_error", err3, 1);
    chk("ch3 busy", busy3, 1);
    chk("ch3 clk_en", clk3, 3'b111);
    chk("ch3 div_valid", dv3, 3'b000);
    chk("ch3 cur", cur3, 12'h111);
    chk("ch3 divo", divo3, 12'h111);
    @(negedge clk_i);
    chk("ch3 back to idle", rdy3, 1);
    chk("ch3 resp dropped", rv3, 0);

    // Program, skip, zero divisor.
    push_req(1, 3);
    wait_idle();
    chk("t2 cur", cur_divisor_o, 16'h1131);
    push_req(1, 3);
    push_req(1, 0);
    wait_idle();
    chk("t3 cur unchanged", cur_divisor_o, 16'h1131);

    // Response back-pressure with a second request waiting.
    @(negedge clk_i);
    rr_force_low = 1'b1;
    push_req(2, 5);
    push_req(3, 9);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!resp_valid_o && n < 100);
    chk("t4 resp seen", resp_valid_o, 1);
    hold = 1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) hold++;
      chk("t4 req_ready while held", req_ready_o, 0);
    end
    rr_force_low = 1'b0;
    @(negedge clk_i);
    if (resp_valid_o && resp_ready_i) hold++;
    chk("t4 resp_valid hold cycles", hold, 11);
    wait_idle();
    chk("t4 cur", cur_divisor_o, 16'h9531);

    // Reset in the middle of SETTLE.
    push_req(0, 2);
    n = 0;
    while (exp_q.size() == 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("t5 accepted", (exp_q.size() > 0), 1);
    t0 = (exp_q.size() > 0) ? exp_q[0].t : cyc;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (cyc < t0 + 20 && n < 100);
    chk("t5 gated before reset", clk_en_o[0], 0);
    chk("t5 busy before reset", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("t5 clk_en0 async", clk_en_o[0], 1);
    chk("t5 busy async", busy_o, 0);
    chk("t5 cur0 async", cur_divisor_o[3:0], 4'd1);
    chk("t5 divo0 async", div_divisor_o[3:0], 4'd1);
    chk("t5 cur all async", cur_divisor_o, 16'h1111);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t5 ready after release", req_ready_o, 1);

    // Two channels in turn.
    push_req(0, 7);
    push_req(3, 2);
    wait_idle();
    chk("t6 cur", cur_divisor_o, 16'h2117);

    // Randomized requests with random response back-pressure.
    @(negedge clk_i);
    rr_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ch = $urandom_range(0, NC - 1);
      r  = $urandom_range(0, 9);
      if (r == 0) push_req(ch, 0);
      else if (r < 3) push_req(ch, int'(mcur[ch]));
      else push_req(ch, $urandom_range(1, 15));
    end
    wait_idle();
    rr_random = 1'b0;
    chk("final cur matches model", cur_divisor_o, pack_model());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
